decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Decode/issue stage feeding the execute ALU; it is the producer of pc/insn/rsData/rtData/imm/ALUOp.
//  It holds the 32x32 register file and generates ALUOp and the extended immediate.
//  A scoreboard interlocks RAW/WAW hazards against the writeback port.
//  One pipeline register with a valid/ready handshake on both sides; flush support for branch redirect.
// PARAMETERS
//  NREG   32  number of architectural registers ($0 hardwired to zero)
//  DW     32  data/insn/pc width
// PORTS
//  clock      in   1   single clock; all state updates on posedge
//  reset_n    in   1   synchronous, active-low reset
//  in_valid   in   1   fetch presents in_pc/in_insn
//  in_ready   out  1   stage accepts this cycle
//  in_pc      in   32  pc of incoming insn
//  in_insn    in   32  incoming instruction word
//  flush      in   1   kill held and incoming insn (branch/jump redirect)
//  wb_en      in   1   writeback write enable
//  wb_addr    in   5   writeback register index
//  wb_data    in   32  writeback data
//  out_valid  out  1   execute-side outputs valid
//  out_ready  in   1   execute consumes this cycle
//  pc, insn   out  32  registered copies for execute
//  rsData     out  32  value of rs (insn[25:21])
//  rtData     out  32  value of rt (insn[20:16])
//  imm        out  32  extended immediate
//  ALUOp      out  6   funct for R-type and MUL (op 011100); otherwise the opcode
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): out_valid=0; pc/insn/rsData/rtData/imm/ALUOp=0; scoreboard clear; all regs=0.
//  Latency: 1 cycle; accepted on edge N, visible with out_valid=1 after edge N.
//  accept = in_valid & in_ready; in_ready = (!out_valid | out_ready) & !hazard & !flush.
//  out_valid: set on accept; cleared on out_valid&out_ready without accept; cleared by flush (flush wins).
//  Outputs hold stable while out_valid & !out_ready.
//  Register read: bypass: if wb_en & wb_addr==src & src!=0, use wb_data, else use the array; $0 always reads 0.
//  wb_en to $0 is ignored.
//  imm: sign-extend insn[15:0]; zero-extend for ANDI/ORI/XORI; LUI gives {insn[15:0],16'h0}.
//  dest(insn):
//   R-type rd, except JR/MULT/MULTU/DIV/DIVU (none).
//   MUL: rd.
//   ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI/LW/LB/LBU: rt.
//   JAL: 31.
//   SW/SB/BEQ/BNE/BGTZ/J: none.
//   Index 0 is treated as none.
//  Scoreboard busy[31:1]:
//   set busy[dest(insn)] when held insn leaves (out_valid&out_ready);
//   clear busy[wb_addr] on wb_en;
//   same reg set and cleared in the same cycle -> set wins.
//  pend(r) = (busy[r] & !(wb_en&wb_addr==r)) | (out_valid & dest(insn)==r); r=0 never pending.
//  hazard = in_valid & (pend(rs) | pend(rt) | pend(dest(in_insn))); sources only where the insn reads them.
//  WAW stalls, so one bit per register suffices.
//  Flush: the held insn never marks the scoreboard; already-set busy bits remain until writeback.
//  Reset mid-operation: all in-flight state dropped; no writeback is expected after reset.
// STRUCTURE
//  mips_defs.vh: opcode/funct constants (RTYPE, MUL_OP, MUL_FUNC, ADDI..BGTZ, J, JAL, funct codes), shared with the ALU.
//  Sub-module reg_file: 2 async read ports with wb bypass, 1 sync write port, synchronous reset.
//  Top level: dest/imm/ALUOp decode functions, scoreboard, output register, handshake.
// TESTING
//  1. Reset held 2 cycles, then ADDI $1,$0,-5 -> next cycle out_valid=1, imm=32'hFFFFFFFB, ALUOp=001000, rsData=0.
//  2. wb_en=1 wb_addr=3 wb_data=0x1234 with accept of ADD $4,$3,$3 in the same cycle -> rsData=rtData=0x1234.
//  3. Issue ADDI $2 and consume it; then ADD $5,$2,$2 -> in_ready=0 until wb_en wb_addr=2 (accepted that cycle, bypassed data).
//  4. out_ready=0 for 3 cycles with insn held -> outputs stable, in_ready=0; out_ready=1 -> next insn accepted same cycle.
//  5. flush with held LW $7 -> out_valid=0 next cycle, busy[7]=0, a following insn reading $7 is accepted without stall.
//  6. ORI $1,$0,0x8000 -> imm=0x00008000; LUI $1,0x8000 -> imm=0x80000000; write to $0 then read $0 -> 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode constants for the decode/issue stage: MIPS opcodes, funct codes and the decode record.
package decode_stage_pkg;

  localparam int AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // dest == 0 means the instruction writes no register
  typedef struct packed {
    logic [AW-1:0] dest;
    logic          rd_rs;
    logic          rd_rt;
  } dec_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file, $0 hardwired to zero; two async read ports bypass a same-cycle writeback.
// Read latency 0, write lands on the next edge; no backpressure.
module decode_stage_reg_file
  import decode_stage_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == '0) rs_data = '0;
    else if (wb_en && wb_addr == rs_addr) rs_data = wb_data;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0) rt_data = '0;
    else if (wb_en && wb_addr == rt_addr) rt_data = wb_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode/issue stage: register read, immediate/ALUOp decode, RAW/WAW scoreboard against writeback.
// One-cycle latency through a single output register; stalls fetch on hazard, full output or flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_insn,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] insn,
  output logic [DW-1:0] rsData,
  output logic [DW-1:0] rtData,
  output logic [DW-1:0] imm,
  output logic [5:0]    ALUOp
);

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct,
                                  input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    dec_t d;
    d = '{dest: '0, rd_rs: 1'b0, rd_rt: 1'b0};
    case (op)
      OP_RTYPE: begin
        d.rd_rs = 1'b1;
        d.rd_rt = (funct != FN_JR);
        if (!(funct inside {FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU})) d.dest = rd;
      end
      OP_MUL: begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
        d.dest  = rd;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_LB, OP_LBU: begin
        d.rd_rs = 1'b1;
        d.dest  = rt;
      end
      OP_LUI: d.dest = rt;
      OP_JAL: d.dest = AW'(31);
      OP_SW, OP_SB, OP_BEQ, OP_BNE: begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
      end
      OP_BGTZ: d.rd_rs = 1'b1;
      OP_J:    d.dest  = '0;
      default: d.dest  = '0;
    endcase
    return d;
  endfunction

  function automatic logic [AW-1:0] dest_of(input logic [DW-1:0] word);
    dec_t d;
    d = decode(word[31:26], word[5:0], word[20:16], word[15:11]);
    return d.dest;
  endfunction

  function automatic logic [DW-1:0] ext_imm(input logic [5:0] op, input logic [15:0] i16);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: return DW'({16'h0, i16});
      OP_LUI:                   return DW'({i16, 16'h0});
      default:                  return {{(DW-16){i16[15]}}, i16};
    endcase
  endfunction

  dec_t            in_dec;
  logic [AW-1:0]   in_rs, in_rt, held_dest;
  logic [DW-1:0]   rd_rs_data, rd_rt_data;
  logic [NREG-1:0] busy, busy_nxt, pend;
  logic            hazard, accept, leave;

  assign in_rs     = in_insn[25:21];
  assign in_rt     = in_insn[20:16];
  assign in_dec    = decode(in_insn[31:26], in_insn[5:0], in_rt, in_insn[15:11]);
  assign held_dest = dest_of(insn);

  // Held insn counts as pending until it leaves; its busy bit is set only on departure.
  always_comb begin
    pend = '0;
    for (int r = 1; r < NREG; r++)
      pend[r] = (busy[r] && !(wb_en && wb_addr == AW'(r))) ||
                (out_valid && held_dest == AW'(r));
  end

  assign hazard   = in_valid && ((in_dec.rd_rs && pend[in_rs]) ||
                                 (in_dec.rd_rt && pend[in_rt]) ||
                                 pend[in_dec.dest]);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign leave    = out_valid && out_ready && !flush;

  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (wb_en && wb_addr == AW'(r)) busy_nxt[r] = 1'b0;
      if (leave && held_dest == AW'(r)) busy_nxt[r] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  decode_stage_reg_file #(.NREG(NREG), .DW(DW)) u_reg_file (
    .clock   (clock),
    .reset_n (reset_n),
    .rs_addr (in_rs),
    .rt_addr (in_rt),
    .rs_data (rd_rs_data),
    .rt_data (rd_rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy      <= '0;
      out_valid <= 1'b0;
      pc        <= '0;
      insn      <= '0;
      rsData    <= '0;
      rtData    <= '0;
      imm       <= '0;
      ALUOp     <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        pc     <= in_pc;
        insn   <= in_insn;
        rsData <= rd_rs_data;
        rtData <= rd_rt_data;
        imm    <= ext_imm(in_insn[31:26], in_insn[15:0]);
        ALUOp  <= (in_insn[31:26] == OP_RTYPE || in_insn[31:26] == OP_MUL) ?
                  in_insn[5:0] : in_insn[31:26];
      end
    end
  end

endmodule
